board_rst_seq: RTL and testbench

Parametrised board-level reset sequencer for the FPGA system top, sitting between the MMCM and the SoC reset inputs. It debounces the two board reset buttons and qualifies the MMCM `locked` signal. It then releases NUM_RST reset domains in a fixed staggered order, and records the cause of the last reset for software. It replaces the ad-hoc combination of the button AND-gate and the single-output processor-system reset IP.

---
 rtl/board_rst_seq.sv | 188 ++++++++++++++++++
 tb/tb_board_rst_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_rst_seq.sv
// Board reset sequencer: debounces two buttons, qualifies MMCM lock, releases NUM_RST domains staggered.
// Optional feature: define BOARD_RST_SWREQ_EN to honour sw_req_i as a reset source (cause 11).
module board_rst_seq #(
  parameter int NUM_RST      = 3,
  parameter int DEB_CYCLES   = 16000,
  parameter int LOCK_CYCLES  = 256,
  parameter int STAGE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_fpga_n_i,
  input  logic               btn_mcu_i,
  input  logic               locked_i,
  input  logic               sw_req_i,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic [1:0]         rst_cause_o,
  output logic               busy_o
);
  localparam int DEB_W   = $clog2(DEB_CYCLES) + 1;
  localparam int LOCK_W  = $clog2(LOCK_CYCLES) + 1;
  localparam int STAGE_W = $clog2(STAGE_CYCLES) + 1;
  localparam int IDX_W   = $clog2(NUM_RST) + 1;

  typedef enum logic [1:0] {ST_ASSERT, ST_WAIT_LOCK, ST_RELEASE, ST_RUN} state_t;

  logic fpga_p0, fpga_p1, mcu_p0, mcu_p1, lock_p0, lock_p1;
  logic fpga_lvl, mcu_lvl, btn_pressed, btn_q;
  logic [DEB_W-1:0] fpga_cnt, mcu_cnt;
  logic sw_evt;

  state_t               state, state_nxt;
  logic [STAGE_W-1:0]   hold_cnt, hold_nxt, stage_cnt, stage_nxt;
  logic [LOCK_W-1:0]    lock_cnt, lock_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [NUM_RST-1:0]   rst_nxt;
  logic [1:0]           cause_nxt;
  logic                 btn_evt, lock_evt;

  // Stage p0/p1: two-flop synchronisers, reset to the idle / unlocked levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpga_p0 <= 1'b1;
      fpga_p1 <= 1'b1;
      mcu_p0  <= 1'b0;
      mcu_p1  <= 1'b0;
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      fpga_p0 <= btn_fpga_n_i;
      fpga_p1 <= fpga_p0;
      mcu_p0  <= btn_mcu_i;
      mcu_p1  <= mcu_p0;
      lock_p0 <= locked_i;
      lock_p1 <= lock_p0;
    end
  end

  // Debounce: level flips once DEB_CYCLES consecutive samples have disagreed with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpga_lvl <= 1'b1;
      fpga_cnt <= '0;
    end else if (fpga_cnt >= DEB_W'(DEB_CYCLES)) begin
      fpga_lvl <= ~fpga_lvl;
      fpga_cnt <= '0;
    end else if (fpga_p1 != fpga_lvl) begin
      fpga_cnt <= fpga_cnt + DEB_W'(1);
    end else begin
      fpga_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcu_lvl <= 1'b0;
      mcu_cnt <= '0;
    end else if (mcu_cnt >= DEB_W'(DEB_CYCLES)) begin
      mcu_lvl <= ~mcu_lvl;
      mcu_cnt <= '0;
    end else if (mcu_p1 != mcu_lvl) begin
      mcu_cnt <= mcu_cnt + DEB_W'(1);
    end else begin
      mcu_cnt <= '0;
    end
  end

  assign btn_pressed = ~fpga_lvl | mcu_lvl;

`ifdef BOARD_RST_SWREQ_EN
  logic sw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_q <= 1'b0;
    else        sw_q <= sw_req_i;
  end

  assign sw_evt = sw_q;
`else
  logic sw_unused;

  assign sw_unused = sw_req_i;
  assign sw_evt    = 1'b0;
`endif

  // Sequencer state and all outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ASSERT;
      hold_cnt    <= '0;
      lock_cnt    <= '0;
      stage_cnt   <= '0;
      idx         <= '0;
      btn_q       <= 1'b0;
      rst_n_o     <= '0;
      rst_cause_o <= 2'b00;
      busy_o      <= 1'b1;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      lock_cnt    <= lock_nxt;
      stage_cnt   <= stage_nxt;
      idx         <= idx_nxt;
      btn_q       <= btn_pressed;
      rst_n_o     <= rst_nxt;
      rst_cause_o <= cause_nxt;
      busy_o      <= (state_nxt != ST_RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    lock_nxt  = lock_cnt;
    stage_nxt = stage_cnt;
    idx_nxt   = idx;
    rst_nxt   = rst_n_o;
    cause_nxt = rst_cause_o;
    btn_evt   = btn_pressed & ~btn_q;
    // Lock loss only counts once release has started; in WAIT_LOCK it just restarts the count
    lock_evt  = ~lock_p1 & ((state == ST_RELEASE) | (state == ST_RUN));

    if ((state != ST_ASSERT) && (btn_evt | lock_evt | sw_evt)) begin
      state_nxt = ST_ASSERT;
      rst_nxt   = '0;
      hold_nxt  = '0;
      lock_nxt  = '0;
      stage_nxt = '0;
      idx_nxt   = '0;
      cause_nxt = btn_evt ? 2'b01 : (lock_evt ? 2'b10 : 2'b11);
    end else begin
      case (state)
        ST_ASSERT: begin
          rst_nxt = '0;
          if (hold_cnt >= STAGE_W'(STAGE_CYCLES)) begin
            if (!btn_pressed) state_nxt = ST_WAIT_LOCK;
          end else begin
            hold_nxt = hold_cnt + STAGE_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_p1) begin
            lock_nxt = '0;
          end else if (lock_cnt >= LOCK_W'(LOCK_CYCLES)) begin
            rst_nxt[0] = 1'b1;
            stage_nxt  = '0;
            idx_nxt    = IDX_W'(1);
            state_nxt  = (NUM_RST == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            lock_nxt = lock_cnt + LOCK_W'(1);
          end
        end
        ST_RELEASE: begin
          if (stage_cnt >= STAGE_W'(STAGE_CYCLES - 1)) begin
            stage_nxt = '0;
            rst_nxt   = rst_n_o | (NUM_RST'(1) << idx);
            idx_nxt   = idx + IDX_W'(1);
            if (idx == IDX_W'(NUM_RST - 1)) state_nxt = ST_RUN;
          end else begin
            stage_nxt = stage_cnt + STAGE_W'(1);
          end
        end
        ST_RUN:  rst_nxt = '1;
        default: state_nxt = ST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_board_rst_seq.sv
// Self-checking bench for board_rst_seq (NUM_RST=3, DEB=4, LOCK=8, STAGE=4) with a window-based reference model.
module tb_board_rst_seq;
  localparam int NR    = 3;
  localparam int DEB   = 4;
  localparam int LOCK  = 8;
  localparam int STAGE = 4;
  localparam int MAXC  = 4096;
`ifdef BOARD_RST_SWREQ_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_fpga_n, btn_mcu, locked, sw_req;
  logic [NR-1:0] rst_n_o;
  logic [1:0]    rst_cause_o;
  logic          busy_o;

  board_rst_seq #(
    .NUM_RST(NR), .DEB_CYCLES(DEB), .LOCK_CYCLES(LOCK), .STAGE_CYCLES(STAGE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_fpga_n_i(btn_fpga_n), .btn_mcu_i(btn_mcu),
    .locked_i(locked), .sw_req_i(sw_req), .rst_n_o(rst_n_o),
    .rst_cause_o(rst_cause_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: per-edge input history; sequencer milestones found by window checks
  bit         raw_b [2][MAXC];
  bit         raw_l [MAXC];
  bit         raw_sw[MAXC];
  bit         pr    [MAXC];
  bit         lvl   [2];
  int         lastf [2];
  int         seq_start, a_edge, r_edge;
  logic [1:0] m_cause;
  logic [NR-1:0] exp_rst;
  logic       exp_busy;
  bit         mvalid = 1'b0;

  initial begin
    forever begin
      int n;
      int ev;
      bit ok;
      @(posedge clk);
      cyc++;
      n = cyc;
      if (n >= MAXC) begin
        $display("FAIL model_range cycle %0d exceeds %0d", n, MAXC);
        $fatal(1);
      end
      if (!rst_n) begin
        seq_start = n; a_edge = -1; r_edge = -1; m_cause = 2'b00;
        lvl[0] = 1'b1; lvl[1] = 1'b0; lastf[0] = n; lastf[1] = n;
        raw_b[0][n] = 1'b1; raw_b[0][n-1] = 1'b1;
        raw_b[1][n] = 1'b0; raw_b[1][n-1] = 1'b0;
        raw_l[n] = 1'b0; raw_l[n-1] = 1'b0;
        raw_sw[n] = 1'b0;
        pr[n] = 1'b0; pr[n-1] = 1'b0;
        mvalid = 1'b1;
      end else begin
        raw_b[0][n] = btn_fpga_n; raw_b[1][n] = btn_mcu;
        raw_l[n] = locked; raw_sw[n] = sw_req;
        ev = 0;
        if (a_edge >= 0) begin
          if (pr[n-1] && !pr[n-2])                ev = 1;
          else if (r_edge >= 0 && !raw_l[n-2])    ev = 2;
          else if (SW_EN && raw_sw[n-1])          ev = 3;
        end
        if (ev != 0) begin
          seq_start = n; a_edge = -1; r_edge = -1; m_cause = 2'(ev);
        end else if (a_edge < 0) begin
          if (n > seq_start + STAGE && !pr[n-1]) a_edge = n;
        end else if (r_edge < 0) begin
          ok = (n - LOCK >= a_edge + 1);
          if (ok)
            for (int k = n - LOCK; k <= n; k++)
              if (!raw_l[k-2]) ok = 1'b0;
          if (ok) r_edge = n;
        end
        for (int b = 0; b < 2; b++) begin
          bit all_diff;
          all_diff = (n - DEB > lastf[b]);
          if (all_diff)
            for (int k = n - DEB; k <= n - 1; k++)
              if (raw_b[b][k-2] == lvl[b]) all_diff = 1'b0;
          if (all_diff) begin
            lvl[b]   = ~lvl[b];
            lastf[b] = n;
          end
        end
        pr[n] = (lvl[0] == 1'b0) || (lvl[1] == 1'b1);
      end
      for (int k = 0; k < NR; k++)
        exp_rst[k] = (r_edge >= 0) && (n >= r_edge + k * STAGE);
      exp_busy = !((r_edge >= 0) && (n >= r_edge + (NR - 1) * STAGE));
    end
  end

  // Compare DUT against the model once per cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mvalid) begin
        tests++;
        if (rst_n_o !== exp_rst || rst_cause_o !== m_cause || busy_o !== exp_busy) begin
          fails++;
          $display("FAIL model@%0d rst_n_o=%b cause=%b busy=%b required %b %b %b",
                   cyc, rst_n_o, rst_cause_o, busy_o, exp_rst, m_cause, exp_busy);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input logic [NR-1:0] r, input logic [1:0] c, input logic b);
    chk({nm, "_rst"},   32'(rst_n_o),     32'(r));
    chk({nm, "_cause"}, 32'(rst_cause_o), 32'(c));
    chk({nm, "_busy"},  32'(busy_o),      32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, s, u, f, t, c;
    rst_n = 1'b0; btn_fpga_n = 1'b1; btn_mcu = 1'b0; locked = 1'b1; sw_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("por_reset", 3'b000, 2'b00, 1'b1);

    // Power-on: the edge at which rst_n deasserts counts as edge 1
    @(posedge clk); #1; e0 = cyc; rst_n = 1'b1;
    wait_edge(e0 + 13); chk_out("por_e14", 3'b000, 2'b00, 1'b1);
    wait_edge(e0 + 14); chk_out("por_e15", 3'b001, 2'b00, 1'b1);
    wait_edge(e0 + 17); chk_out("por_e18", 3'b001, 2'b00, 1'b1);
    wait_edge(e0 + 18); chk_out("por_e19", 3'b011, 2'b00, 1'b1);
    wait_edge(e0 + 21); chk_out("por_e22", 3'b011, 2'b00, 1'b1);
    wait_edge(e0 + 22); chk_out("por_e23", 3'b111, 2'b00, 1'b0);

    // Bounce on the MCU button, then a stable press
    for (int i = 0; i < 40; i++) begin
      btn_mcu = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    chk_out("bounce_none", 3'b111, 2'b00, 1'b0);
    btn_mcu = 1'b1; s = cyc + 1;
    wait_edge(s + 6);  chk_out("btn_pre", 3'b111, 2'b00, 1'b0);
    wait_edge(s + 7);  chk_out("btn_fall", 3'b000, 2'b01, 1'b1);
    wait_edge(s + 27); chk_out("btn_held", 3'b000, 2'b01, 1'b1);
    btn_mcu = 1'b0; u = cyc + 1;
    wait_edge(u + 15); chk_out("btn_rel_pre", 3'b000, 2'b01, 1'b1);
    wait_edge(u + 16); chk_out("btn_rel_b0", 3'b001, 2'b01, 1'b1);
    wait_edge(u + 20); chk_out("btn_rel_b1", 3'b011, 2'b01, 1'b1);
    wait_edge(u + 24); chk_out("btn_rel_run", 3'b111, 2'b01, 1'b0);

    // Lock glitch in RUN, then a second glitch inside WAIT_LOCK
    locked = 1'b0; f = cyc + 1; @(negedge clk); locked = 1'b1;
    wait_edge(f + 1);  chk_out("lock_pre", 3'b111, 2'b01, 1'b0);
    wait_edge(f + 2);  chk_out("lock_fall", 3'b000, 2'b10, 1'b1);
    wait_edge(f + 9);  locked = 1'b0; @(negedge clk); locked = 1'b1;
    wait_edge(f + 16); chk_out("lock_delay", 3'b000, 2'b10, 1'b1);
    wait_edge(f + 20); chk_out("lock_rel_pre", 3'b000, 2'b10, 1'b1);
    wait_edge(f + 21); chk_out("lock_rel_b0", 3'b001, 2'b10, 1'b1);
    wait_edge(f + 29); chk_out("lock_run", 3'b111, 2'b10, 1'b0);

    // Debounce completion and lock loss land on the same edge
    btn_fpga_n = 1'b0; s = cyc + 1;
    wait_edge(s + 4);  locked = 1'b0;
    wait_edge(s + 6);  locked = 1'b1;
    wait_edge(s + 7);  chk_out("simul", 3'b000, 2'b01, 1'b1);
    wait_edge(s + 10); btn_fpga_n = 1'b1; u = cyc + 1;
    wait_edge(u + 24); chk_out("simul_run", 3'b111, 2'b01, 1'b0);

    // Software request in RUN
    sw_req = 1'b1; t = cyc + 1; @(negedge clk); sw_req = 1'b0;
    wait_edge(t + 1);
    if (SW_EN) chk_out("sw_run", 3'b000, 2'b11, 1'b1);
    else       chk_out("sw_run", 3'b111, 2'b01, 1'b0);
    wait_edge(t + 23);
    if (SW_EN) chk_out("sw_rerun", 3'b111, 2'b11, 1'b0);
    else       chk_out("sw_rerun", 3'b111, 2'b01, 1'b0);

    // Software request mid-release, then a second one during ASSERT
    c = cyc; locked = 1'b0; f = c + 1; @(negedge clk); locked = 1'b1;
    wait_edge(f + 16); chk_out("mid_b0", 3'b001, 2'b10, 1'b1);
    sw_req = 1'b1; @(negedge clk); sw_req = 1'b0;
    wait_edge(f + 18);
    if (SW_EN) chk_out("mid_sw", 3'b000, 2'b11, 1'b1);
    else       chk_out("mid_sw", 3'b001, 2'b10, 1'b1);
    wait_edge(f + 19); sw_req = 1'b1; @(negedge clk); sw_req = 1'b0;
    wait_edge(f + 22);
    if (SW_EN) chk_out("mid_sw2", 3'b000, 2'b11, 1'b1);
    else       chk_out("mid_sw2", 3'b011, 2'b10, 1'b1);
    wait_edge(f + 32);
    if (SW_EN) chk_out("mid_rel", 3'b001, 2'b11, 1'b1);
    else       chk_out("mid_rel", 3'b111, 2'b10, 1'b0);
    wait_edge(f + 40);
    if (SW_EN) chk_out("mid_run", 3'b111, 2'b11, 1'b0);
    else       chk_out("mid_run", 3'b111, 2'b10, 1'b0);

    // Asynchronous reset in the middle of a release sequence
    locked = 1'b0; f = cyc + 1; @(negedge clk); locked = 1'b1;
    wait_edge(f + 17);
    @(posedge clk); #1; rst_n = 1'b0;
    #1; chk_out("async_rst", 3'b000, 2'b00, 1'b1);
    @(posedge clk);
    @(posedge clk); #1; e0 = cyc; rst_n = 1'b1;
    wait_edge(e0 + 14); chk_out("rerst_b0", 3'b001, 2'b00, 1'b1);
    wait_edge(e0 + 22); chk_out("rerst_run", 3'b111, 2'b00, 1'b0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
